// File: rtl/jelly3_axi4l_register_slave.sv
// ---------------------------------------------------------------------------
// jelly3_axi4l_register_slave
//
// AXI4-Lite slave exposing REGS_NUM control registers of DATA_BITS each.
// Writes are byte-maskable and each write pulses a per-register strobe.
// All register contents are presented in parallel on out_regs.
//
// Ports
//   reset, clk        : asynchronous active-high reset, sole clock
//   s_aw*             : write address channel (s_awprot ignored)
//   s_w*              : write data channel
//   s_b*              : write response channel (OKAY / SLVERR)
//   s_ar*             : read address channel (s_arprot ignored)
//   s_r*              : read data channel (OKAY / SLVERR, data 0 on error)
//   out_regs          : register i at [i*DATA_BITS +: DATA_BITS], straight
//                       from the register flops
//   out_wr_pulse      : one-cycle strobe per register, raised together with
//                       the first cycle of s_bvalid for an in-range write
// ---------------------------------------------------------------------------
module jelly3_axi4l_register_slave #(
    parameter int                    ADDR_BITS  = 32,
    parameter int                    DATA_BITS  = 32,
    parameter int                    REGS_NUM   = 8,
    parameter logic [ADDR_BITS-1:0]  ADDR_BASE  = '0,
    parameter logic [DATA_BITS-1:0]  INIT_VALUE = '0
) (
    input  logic                            reset,
    input  logic                            clk,

    input  logic [ADDR_BITS-1:0]            s_awaddr,
    input  logic [2:0]                      s_awprot,
    input  logic                            s_awvalid,
    output logic                            s_awready,

    input  logic [DATA_BITS-1:0]            s_wdata,
    input  logic [DATA_BITS/8-1:0]          s_wstrb,
    input  logic                            s_wvalid,
    output logic                            s_wready,

    output logic [1:0]                      s_bresp,
    output logic                            s_bvalid,
    input  logic                            s_bready,

    input  logic [ADDR_BITS-1:0]            s_araddr,
    input  logic [2:0]                      s_arprot,
    input  logic                            s_arvalid,
    output logic                            s_arready,

    output logic [DATA_BITS-1:0]            s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rvalid,
    input  logic                            s_rready,

    output logic [REGS_NUM*DATA_BITS-1:0]   out_regs,
    output logic [REGS_NUM-1:0]             out_wr_pulse
);

    localparam int STRB_BITS  = DATA_BITS / 8;
    localparam int ADDR_SHIFT = (STRB_BITS > 1) ? $clog2(STRB_BITS) : 0;
    localparam int IDX_BITS   = (REGS_NUM > 1) ? $clog2(REGS_NUM) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Protection bits carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{s_awprot, s_arprot};

    // -----------------------------------------------------------------------
    // Address decode. The subtraction is done one bit wider so the borrow
    // flags addresses below ADDR_BASE without a separate magnitude compare.
    // -----------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
        logic [ADDR_BITS:0] diff;
        diff = {1'b0, addr} - {1'b0, ADDR_BASE};
        return !diff[ADDR_BITS]
            && ((diff[ADDR_BITS-1:0] >> ADDR_SHIFT) < ADDR_BITS'(REGS_NUM));
    endfunction

    function automatic logic [IDX_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr);
        logic [ADDR_BITS-1:0] offset;
        offset = (addr - ADDR_BASE) >> ADDR_SHIFT;
        return IDX_BITS'(offset);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                   aw_held_q, aw_held_d;
    logic [ADDR_BITS-1:0]   awaddr_q,  awaddr_d;
    logic                   w_held_q,  w_held_d;
    logic [DATA_BITS-1:0]   wdata_q,   wdata_d;
    logic [STRB_BITS-1:0]   wstrb_q,   wstrb_d;
    logic                   bvalid_q,  bvalid_d;
    logic [1:0]             bresp_q,   bresp_d;
    logic [REGS_NUM-1:0]    wr_pulse_q, wr_pulse_d;

    logic                   rvalid_q,  rvalid_d;
    logic [DATA_BITS-1:0]   rdata_q,   rdata_d;
    logic [1:0]             rresp_q,   rresp_d;

    // Register file views
    logic [REGS_NUM*DATA_BITS-1:0]  regs_flat;
    logic [DATA_BITS-1:0]           regs_arr [REGS_NUM];

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    logic                   aw_ready;
    logic                   w_ready;
    logic                   aw_fire;
    logic                   w_fire;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [DATA_BITS-1:0]   wr_data;
    logic [STRB_BITS-1:0]   wr_strb;
    logic                   wr_commit;
    logic                   wr_hit;
    logic [IDX_BITS-1:0]    wr_idx;
    logic [REGS_NUM-1:0]    wr_sel;

    always_comb begin
        // Readies are forced low while reset is asserted; as soon as reset
        // drops the cleared state makes them high in that same cycle.
        aw_ready  = !reset && !aw_held_q && !bvalid_q;
        w_ready   = !reset && !w_held_q  && !bvalid_q;
        aw_fire   = s_awvalid && aw_ready;
        w_fire    = s_wvalid  && w_ready;

        // A beat that is handshaking this cycle can commit immediately, so
        // the commit sources come from either the holding register or the bus.
        wr_addr   = aw_held_q ? awaddr_q : s_awaddr;
        wr_data   = w_held_q  ? wdata_q  : s_wdata;
        wr_strb   = w_held_q  ? wstrb_q  : s_wstrb;
        wr_commit = (aw_held_q || aw_fire) && (w_held_q || w_fire);
        wr_hit    = wr_commit && addr_in_range(wr_addr);
        wr_idx    = addr_index(wr_addr);
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = wr_sel;

        if (aw_fire) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_awaddr;
        end
        if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
        end

        // Readies are low while bvalid is up, so a commit and a pending
        // response can never coincide.
        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_bready) begin
            bvalid_d  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Register file: one flop bank per register with byte-lane enables
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < REGS_NUM; gi++) begin : g_reg
            logic [DATA_BITS-1:0] reg_q, reg_d;

            assign wr_sel[gi] = wr_hit && (wr_idx == IDX_BITS'(gi));

            always_comb begin
                reg_d = reg_q;
                if (wr_sel[gi]) begin
                    for (int b = 0; b < STRB_BITS; b++) begin
                        if (wr_strb[b]) begin
                            reg_d[b*8 +: 8] = wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    reg_q <= INIT_VALUE;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_flat[gi*DATA_BITS +: DATA_BITS] = reg_q;
            assign regs_arr[gi]                         = reg_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read path: single outstanding read, data captured at the AR handshake
    // edge so a write committing on the same edge is not yet visible.
    // -----------------------------------------------------------------------
    logic                   ar_ready;
    logic                   ar_fire;
    logic [IDX_BITS-1:0]    rd_idx;
    logic                   rd_hit;

    always_comb begin
        ar_ready = !reset && !rvalid_q;
        ar_fire  = s_arvalid && ar_ready;
        rd_hit   = addr_in_range(s_araddr);
        rd_idx   = addr_index(s_araddr);

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_hit ? regs_arr[rd_idx] : '0;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Channel state flops
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s_awready    = aw_ready;
    assign s_wready     = w_ready;
    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_arready    = ar_ready;
    assign s_rvalid     = rvalid_q;
    assign s_rdata      = rdata_q;
    assign s_rresp      = rresp_q;
    assign out_regs     = regs_flat;
    assign out_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_jelly3_axi4l_register_slave.sv
// ---------------------------------------------------------------------------
// Testbench for jelly3_axi4l_register_slave (8 x 32-bit registers, base 0,
// non-zero reset value so reset and partial-strobe effects are visible).
// Write responses and read data are predicted when each request is driven and
// checked by a monitor when the corresponding B/R handshake takes place.
// ---------------------------------------------------------------------------
module tb_jelly3_axi4l_register_slave;

    localparam int          REGS_NUM = 8;
    localparam logic [31:0] INIT     = 32'hA5A5_A5A5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [31:0]            s_awaddr = '0;
    logic [2:0]             s_awprot = '0;
    logic                   s_awvalid = 1'b0;
    logic                   s_awready;
    logic [31:0]            s_wdata = '0;
    logic [3:0]             s_wstrb = '0;
    logic                   s_wvalid = 1'b0;
    logic                   s_wready;
    logic [1:0]             s_bresp;
    logic                   s_bvalid;
    logic                   s_bready = 1'b1;
    logic [31:0]            s_araddr = '0;
    logic [2:0]             s_arprot = '0;
    logic                   s_arvalid = 1'b0;
    logic                   s_arready;
    logic [31:0]            s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rvalid;
    logic                   s_rready = 1'b1;
    logic [REGS_NUM*32-1:0] out_regs;
    logic [REGS_NUM-1:0]    out_wr_pulse;

    always #5 clk = ~clk;

    jelly3_axi4l_register_slave #(
        .ADDR_BITS  (32),
        .DATA_BITS  (32),
        .REGS_NUM   (REGS_NUM),
        .ADDR_BASE  (32'h0),
        .INIT_VALUE (INIT)
    ) dut (
        .reset        (reset),
        .clk          (clk),
        .s_awaddr     (s_awaddr),
        .s_awprot     (s_awprot),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arprot     (s_arprot),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .out_regs     (out_regs),
        .out_wr_pulse (out_wr_pulse)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference register contents
    logic [31:0] model [REGS_NUM];

    function automatic void model_reset();
        for (int i = 0; i < REGS_NUM; i++) model[i] = INIT;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        if (addr < 32'(REGS_NUM * 4)) begin
            idx = int'(addr >> 2);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < REGS_NUM; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard queues and monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [1:0] b_q [$];
    r_exp_t     r_q [$];
    logic [1:0] b_exp;
    r_exp_t     r_exp;

    always @(negedge clk) begin
        if (!reset && s_bvalid && s_bready) begin
            if (b_q.size() == 0) begin
                fail_now("b_unexpected");
            end else begin
                b_exp = b_q.pop_front();
                chk("bresp", s_bresp, b_exp);
                $display("B  resp=%0h", s_bresp);
            end
        end
        if (!reset && s_rvalid && s_rready) begin
            if (r_q.size() == 0) begin
                fail_now("r_unexpected");
            end else begin
                r_exp = r_q.pop_front();
                chk("rdata", s_rdata, r_exp.data);
                chk("rresp", s_rresp, r_exp.resp);
                $display("R  data=%08h resp=%0h", s_rdata, s_rresp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at posedge+1)
    // ------------------------------------------------------------------
    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr_ready();
        int n = 0;
        while (!(s_awready && s_wready) && n < 20) begin
            wait_cycle();
            n++;
        end
        if (n == 20) fail_now("wr_ready_timeout");
    endtask

    task automatic wait_ar_ready();
        int n = 0;
        while (!s_arready && n < 20) begin
            wait_cycle();
            n++;
        end
        if (n == 20) fail_now("ar_ready_timeout");
    endtask

    // AW and W presented in the same cycle; checks commit-cycle outputs.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic [7:0] exp_pulse, input string name);
        wait_wr_ready();
        s_awaddr  = addr;
        s_awvalid = 1'b1;
        s_wdata   = data;
        s_wstrb   = strb;
        s_wvalid  = 1'b1;
        b_q.push_back(exp_resp);
        model_write(addr, data, strb);
        wait_cycle();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        $display("W  %s addr=%08h data=%08h strb=%0h", name, addr, data, strb);
        chk({name, "_bvalid"}, s_bvalid, 1'b1);
        chk({name, "_pulse"}, out_wr_pulse, exp_pulse);
        chk({name, "_regs"}, out_regs, model_flat());
        wait_cycle();
        chk({name, "_pulse_clr"}, out_wr_pulse, 8'h00);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string name);
        wait_ar_ready();
        s_araddr  = addr;
        s_arvalid = 1'b1;
        r_q.push_back({exp_data, exp_resp});
        wait_cycle();
        s_arvalid = 1'b0;
        $display("AR %s addr=%08h", name, addr);
        chk({name, "_rvalid"}, s_rvalid, 1'b1);
        wait_cycle();
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] val;    // register value after a write / read data
    } vec_t;

    vec_t vec [12];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int idx;

        vec[0]  = '{1'b1, 32'h04,       32'hDEADBEEF, 4'hF, 2'b00, 8'h02, 32'hDEADBEEF};
        vec[1]  = '{1'b0, 32'h04,       32'h0,        4'h0, 2'b00, 8'h00, 32'hDEADBEEF};
        vec[2]  = '{1'b1, 32'h1C,       32'h01020304, 4'h3, 2'b00, 8'h80, 32'hA5A50304};
        vec[3]  = '{1'b0, 32'h1C,       32'h0,        4'h0, 2'b00, 8'h00, 32'hA5A50304};
        vec[4]  = '{1'b1, 32'h0E,       32'hFFFFFFFF, 4'h8, 2'b00, 8'h08, 32'hFFA5A5A5};
        vec[5]  = '{1'b0, 32'h0D,       32'h0,        4'h0, 2'b00, 8'h00, 32'hFFA5A5A5};
        vec[6]  = '{1'b1, 32'h14,       32'h12345678, 4'h0, 2'b00, 8'h20, 32'hA5A5A5A5};
        vec[7]  = '{1'b0, 32'h14,       32'h0,        4'h0, 2'b00, 8'h00, 32'hA5A5A5A5};
        vec[8]  = '{1'b0, 32'h100,      32'h0,        4'h0, 2'b10, 8'h00, 32'h0};
        vec[9]  = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 2'b10, 8'h00, 32'h0};
        vec[10] = '{1'b0, 32'h20,       32'h0,        4'h0, 2'b10, 8'h00, 32'h0};
        vec[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 2'b10, 8'h00, 32'h0};

        model_reset();

        // ---- reset state ----
        wait_cycle();
        wait_cycle();
        chk("rst_awready", s_awready, 1'b0);
        chk("rst_wready",  s_wready,  1'b0);
        chk("rst_arready", s_arready, 1'b0);
        chk("rst_bvalid",  s_bvalid,  1'b0);
        chk("rst_rvalid",  s_rvalid,  1'b0);
        chk("rst_bresp",   s_bresp,   2'b00);
        chk("rst_rresp",   s_rresp,   2'b00);
        chk("rst_rdata",   s_rdata,   32'h0);
        chk("rst_pulse",   out_wr_pulse, 8'h00);
        chk("rst_regs",    out_regs,  model_flat());
        reset = 1'b0;
        #1;
        chk("rel_awready", s_awready, 1'b1);
        chk("rel_wready",  s_wready,  1'b1);
        chk("rel_arready", s_arready, 1'b1);
        wait_cycle();

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
            if (vec[i].is_wr) begin
                do_write(vec[i].addr, vec[i].data, vec[i].strb, vec[i].resp,
                         vec[i].pulse, $sformatf("vec%0d", i));
                if (vec[i].resp == 2'b00) begin
                    idx = int'(vec[i].addr >> 2);
                    chk($sformatf("vec%0d_reg", i), out_regs[idx*32 +: 32], vec[i].val);
                end
            end else begin
                do_read(vec[i].addr, vec[i].val, vec[i].resp, $sformatf("vec%0d", i));
            end
        end

        // ---- W arrives three cycles before AW ----
        do_write(32'h08, 32'h0, 4'hF, 2'b00, 8'h04, "clr_reg2");
        s_wdata  = 32'h11223344;
        s_wstrb  = 4'h5;
        s_wvalid = 1'b1;
        wait_cycle();
        s_wvalid = 1'b0;
        $display("W  early data=11223344 strb=5");
        for (int k = 0; k < 3; k++) begin
            chk("wfirst_wready",  s_wready,  1'b0);
            chk("wfirst_awready", s_awready, 1'b1);
            chk("wfirst_bvalid",  s_bvalid,  1'b0);
            chk("wfirst_pulse",   out_wr_pulse, 8'h00);
            wait_cycle();
        end
        s_awaddr  = 32'h08;
        s_awvalid = 1'b1;
        b_q.push_back(2'b00);
        model_write(32'h08, 32'h11223344, 4'h5);
        wait_cycle();
        s_awvalid = 1'b0;
        $display("AW late addr=00000008");
        chk("wfirst_commit_bvalid", s_bvalid, 1'b1);
        chk("wfirst_commit_pulse",  out_wr_pulse, 8'h04);
        chk("wfirst_reg2", out_regs[2*32 +: 32], 32'h00220044);
        chk("wfirst_regs", out_regs, model_flat());
        wait_cycle();

        // ---- B back-pressure for 5 cycles ----
        s_bready = 1'b0;
        wait_wr_ready();
        s_awaddr  = 32'h10;
        s_awvalid = 1'b1;
        s_wdata   = 32'hCAFEF00D;
        s_wstrb   = 4'hF;
        s_wvalid  = 1'b1;
        b_q.push_back(2'b00);
        model_write(32'h10, 32'hCAFEF00D, 4'hF);
        wait_cycle();
        $display("W  stall addr=00000010 data=cafef00d");
        chk("stall_commit_pulse", out_wr_pulse, 8'h10);
        // second write presented immediately; must not be taken yet
        s_awaddr = 32'h18;
        s_wdata  = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            chk("stall_bvalid",  s_bvalid,  1'b1);
            chk("stall_bresp",   s_bresp,   2'b00);
            chk("stall_awready", s_awready, 1'b0);
            chk("stall_wready",  s_wready,  1'b0);
            chk("stall_regs",    out_regs,  model_flat());
            wait_cycle();
        end
        s_bready = 1'b1;
        b_q.push_back(2'b00);
        wait_cycle();
        chk("unstall_bvalid",  s_bvalid,  1'b0);
        chk("unstall_awready", s_awready, 1'b1);
        chk("unstall_wready",  s_wready,  1'b1);
        model_write(32'h18, 32'h0BADF00D, 4'hF);
        wait_cycle();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        $display("W  after-stall addr=00000018 data=0badf00d");
        chk("second_bvalid", s_bvalid, 1'b1);
        chk("second_pulse",  out_wr_pulse, 8'h40);
        chk("second_reg6",   out_regs[6*32 +: 32], 32'h0BADF00D);
        wait_cycle();

        // ---- read and write of reg0 on the same edge ----
        wait_wr_ready();
        wait_ar_ready();
        s_araddr  = 32'h0;
        s_arvalid = 1'b1;
        s_awaddr  = 32'h0;
        s_awvalid = 1'b1;
        s_wdata   = 32'h12345678;
        s_wstrb   = 4'hF;
        s_wvalid  = 1'b1;
        r_q.push_back({model[0], 2'b00});
        b_q.push_back(2'b00);
        model_write(32'h0, 32'h12345678, 4'hF);
        wait_cycle();
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        $display("RW same-edge reg0 data=12345678");
        chk("rw_rvalid", s_rvalid, 1'b1);
        chk("rw_pulse",  out_wr_pulse, 8'h01);
        wait_cycle();
        do_read(32'h0, 32'h12345678, 2'b00, "rd_after_wr");

        // ---- read throughput with arvalid held ----
        hs = 0;
        s_araddr  = 32'h04;
        s_arvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (s_arready) begin
                r_q.push_back({model[1], 2'b00});
                hs++;
            end
            wait_cycle();
        end
        s_arvalid = 1'b0;
        chk("rd_throughput", hs, 4);
        wait_cycle();

        // ---- reset during a held AW and a pending R ----
        s_rready = 1'b0;
        do_read(32'h04, model[1], 2'b00, "rd_pending");
        s_awaddr  = 32'h18;
        s_awvalid = 1'b1;
        wait_cycle();
        s_awvalid = 1'b0;
        chk("pre_rst_awready", s_awready, 1'b0);
        chk("pre_rst_rvalid",  s_rvalid,  1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rvalid",  s_rvalid,  1'b0);
        chk("mid_rst_awready", s_awready, 1'b0);
        chk("mid_rst_arready", s_arready, 1'b0);
        wait_cycle();
        // the pending read is discarded by reset
        r_q.delete();
        model_reset();
        chk("mid_rst_regs", out_regs, model_flat());
        reset = 1'b0;
        s_rready = 1'b1;
        #1;
        chk("post_rst_awready", s_awready, 1'b1);
        chk("post_rst_wready",  s_wready,  1'b1);
        chk("post_rst_arready", s_arready, 1'b1);
        s_wdata  = 32'h77777777;
        s_wstrb  = 4'hF;
        s_wvalid = 1'b1;
        wait_cycle();
        s_wvalid = 1'b0;
        $display("W  post-reset data=77777777 (no AW)");
        chk("post_rst_no_commit", s_bvalid, 1'b0);
        chk("post_rst_pulse",     out_wr_pulse, 8'h00);
        chk("post_rst_regs",      out_regs, model_flat());
        s_awaddr  = 32'h18;
        s_awvalid = 1'b1;
        b_q.push_back(2'b00);
        model_write(32'h18, 32'h77777777, 4'hF);
        wait_cycle();
        s_awvalid = 1'b0;
        $display("AW post-reset addr=00000018");
        chk("post_rst_commit", s_bvalid, 1'b1);
        chk("post_rst_pulse6", out_wr_pulse, 8'h40);
        chk("post_rst_regs2",  out_regs, model_flat());
        wait_cycle();
        wait_cycle();

        chk("b_queue_empty", b_q.size(), 0);
        chk("r_queue_empty", r_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
